// File: rtl/pipe_flow_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush/halt
// sequencer.
//   master : datapath side, drives the decoded control and memory handshake.
//   slave  : sequencer side, returns the enables, flushes and status.
interface pipe_flow_ctrl_if;
    // Decoded control from ID and EX, plus the data-memory handshake
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_halt;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;

    // Pipeline register enables, flushes and status
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        back_hold;
    logic        halted;
    logic        mem_err;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_mem_read, ex_rd, ex_redirect, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush,
               back_hold, halted, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_mem_read, ex_rd, ex_redirect, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush,
               back_hold, halted, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Central stall/flush/halt sequencer for the 5-stage RISC-V pipeline.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous, active-low; while low the outputs sit at their
//            safe values (front end frozen, both flushes asserted)
//   bus    : pipe_flow_ctrl_if.slave
//            inputs  : ID source regs/use flags, id_halt, EX MemRead/rd,
//                      ex_redirect, mem_req/mem_ready
//            outputs : pc_write, if_id_write, if_id_flush, id_ex_flush,
//                      back_hold, halted, mem_err, stall_cnt
// The enables and flushes are combinational from state and inputs; the state,
// drain/wait counters, mem_err and stall_cnt are registered.
module pipe_flow_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CW           = 8
) (
    input  logic             clk,
    input  logic             reset,
    pipe_flow_ctrl_if.slave  bus
);

    localparam int unsigned SW  = 2;
    localparam int unsigned SCW = 16;

    localparam logic [SW-1:0] S_RUN      = 2'd0;
    localparam logic [SW-1:0] S_MEM_WAIT = 2'd1;
    localparam logic [SW-1:0] S_DRAIN    = 2'd2;
    localparam logic [SW-1:0] S_HALTED   = 2'd3;

    localparam logic [CW-1:0] DRAIN_INIT  = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

    // State and counters. The wait counter is separate from the drain
    // counter so a memory stall inside DRAIN leaves the drain count intact.
    logic [SW-1:0]  r_state;
    logic [CW-1:0]  r_drain_cnt;
    logic [CW-1:0]  r_wait_cnt;
    logic           r_ret_drain;
    logic           r_mem_err;
    logic [SCW-1:0] r_stall_cnt;

    logic [SW-1:0]  w_nxt_state;
    logic [CW-1:0]  w_nxt_drain;
    logic [CW-1:0]  w_nxt_wait;
    logic           w_nxt_ret;
    logic           w_set_err;

    logic           w_pc_write;
    logic           w_if_id_write;
    logic           w_if_id_flush;
    logic           w_id_ex_flush;
    logic           w_back_hold;
    logic           w_halted;

    logic           w_load_use;
    logic           w_mem_stall;

    // Hazard detection; x0 as a destination never creates a dependency
    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                         (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));
    assign w_mem_stall = bus.mem_req && !bus.mem_ready;

    // Next-state and output decode
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_drain   = r_drain_cnt;
        w_nxt_wait    = r_wait_cnt;
        w_nxt_ret     = r_ret_drain;
        w_set_err     = 1'b0;
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_back_hold   = 1'b0;
        w_halted      = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    w_back_hold = 1'b1;
                    w_nxt_state = S_MEM_WAIT;
                    w_nxt_wait  = CW'(1);
                    w_nxt_ret   = 1'b0;
                end else if (bus.ex_redirect) begin
                    // Wrong-path halt/load-use in ID is squashed by the flushes
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_id_ex_flush = 1'b1;
                end else if (bus.id_halt) begin
                    // Halt is held in ID and never reaches EX
                    w_id_ex_flush = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        w_nxt_state = S_HALTED;
                    end else begin
                        w_nxt_state = S_DRAIN;
                        w_nxt_drain = DRAIN_INIT;
                    end
                end else begin
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                end
            end

            S_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    // Release cycle: back end advances, front end stays frozen
                    w_nxt_state = r_ret_drain ? S_DRAIN : S_RUN;
                end else begin
                    w_back_hold = 1'b1;
                    if (r_wait_cnt == TIMEOUT_VAL) begin
                        w_set_err   = 1'b1;
                        w_nxt_state = S_HALTED;
                    end else begin
                        w_nxt_wait = r_wait_cnt + CW'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (w_mem_stall) begin
                    w_back_hold = 1'b1;
                    w_nxt_state = S_MEM_WAIT;
                    w_nxt_wait  = CW'(1);
                    w_nxt_ret   = 1'b1;
                end else begin
                    w_id_ex_flush = 1'b1;
                    if ((r_drain_cnt == '0) || (r_drain_cnt == CW'(1))) begin
                        w_nxt_drain = '0;
                        w_nxt_state = S_HALTED;
                    end else begin
                        w_nxt_drain = r_drain_cnt - CW'(1);
                    end
                end
            end

            S_HALTED: begin
                w_back_hold = 1'b1;
                w_halted    = 1'b1;
            end

            default: begin
                w_nxt_state = S_RUN;
            end
        endcase
    end

    // State, counters, sticky error and saturating stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
            r_wait_cnt  <= '0;
            r_ret_drain <= 1'b0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_drain_cnt <= w_nxt_drain;
            r_wait_cnt  <= w_nxt_wait;
            r_ret_drain <= w_nxt_ret;
            if (w_set_err) begin
                r_mem_err <= 1'b1;
            end
            if ((r_state != S_HALTED) && !w_pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + SCW'(1);
            end
        end
    end

    // Reset overrides the decode so the pipeline sees safe values immediately
    assign bus.pc_write    = reset && w_pc_write;
    assign bus.if_id_write = reset && w_if_id_write;
    assign bus.if_id_flush = !reset || w_if_id_flush;
    assign bus.id_ex_flush = !reset || w_id_ex_flush;
    assign bus.back_hold   = reset && w_back_hold;
    assign bus.halted      = reset && w_halted;
    assign bus.mem_err     = r_mem_err;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed scoreboard bench for pipe_flow_ctrl. The driver applies one input
// vector per cycle just after the rising edge and queues the hand-computed
// output vector; the monitor pops and compares on the falling edge.
// Flag order: {pc_write, if_id_write, if_id_flush, id_ex_flush, back_hold,
//              halted, mem_err}
module tb_pipe_flow_ctrl;

    logic clk;
    logic reset;

    pipe_flow_ctrl_if bus ();

    pipe_flow_ctrl #(
        .DRAIN_CYCLES (3),
        .MEM_TIMEOUT  (4),
        .CW           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  flags;
        logic [15:0] sc;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the expected outputs for that cycle
    task automatic cyc(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic hlt,
                       input logic exmr, input logic [4:0] exrd, input logic redir,
                       input logic mreq, input logic mrdy,
                       input logic [6:0] ef, input logic [15:0] esc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.id_halt     = hlt;
        bus.ex_mem_read = exmr;
        bus.ex_rd       = exrd;
        bus.ex_redirect = redir;
        bus.mem_req     = mreq;
        bus.mem_ready   = mrdy;
        e.flags = ef;
        e.sc    = esc;
        e.nm    = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, compare whenever one is queued
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t        e;
            logic [6:0]  act;
            e   = exp_q.pop_front();
            act = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                   bus.back_hold, bus.halted, bus.mem_err};
            n_checks++;
            if ((act !== e.flags) || (bus.stall_cnt !== e.sc)) begin
                n_fail++;
                $display("FAIL %s: got flags=%b stall_cnt=%0d, expected flags=%b stall_cnt=%0d",
                         e.nm, act, bus.stall_cnt, e.flags, e.sc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_use_rs1  = 1'b0;
        bus.id_use_rs2  = 1'b0;
        bus.id_halt     = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_redirect = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ready   = 1'b0;

        //   rst rs1   rs2   u1 u2 hl mr exrd  rd mq my  flags         cnt
        // Reset forces safe outputs even with a halt/redirect present
        cyc(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 0, 0, 7'b0011000, 16'd0,  "reset_forced");
        // Load-use hazards
        cyc(1, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0, 0, 7'b0001000, 16'd0,  "load_use_rs1");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b1100000, 16'd1,  "after_load_use");
        cyc(1, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, 0, 7'b1100000, 16'd1,  "load_x0_no_stall");
        cyc(1, 5'd3, 5'd7, 1, 1, 0, 1, 5'd7, 0, 0, 0, 7'b0001000, 16'd1,  "load_use_rs2");
        cyc(1, 5'd3, 5'd7, 1, 0, 0, 1, 5'd7, 0, 0, 0, 7'b1100000, 16'd2,  "rs2_unused_no_stall");
        // Redirect beats load-use and halt, stays in RUN
        cyc(1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 0, 0, 7'b1111000, 16'd2,  "redirect_wins");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b1100000, 16'd2,  "still_run");
        // Memory wait: 4 not-ready cycles then a release cycle
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd2,  "mem_wait_1");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd3,  "mem_wait_2");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd4,  "mem_wait_3");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd5,  "mem_wait_4");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 7'b0000000, 16'd6,  "mem_release");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b1100000, 16'd7,  "mem_back_to_run");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 7'b1100000, 16'd7,  "mem_ready_no_stall");
        // Memory stall beats redirect
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 7'b0000100, 16'd7,  "mem_beats_redirect");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 7'b0000000, 16'd8,  "mem_release_2");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b1100000, 16'd9,  "run_again");
        // Halt drain: halted on the 5th cycle, redirect/halt ignored in DRAIN
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd9,  "halt_in_id");
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 0, 0, 7'b0001000, 16'd10, "drain_1");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd11, "drain_2");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd12, "drain_3");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0000110, 16'd13, "halted");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000110, 16'd13, "halted_frozen");
        // Reset out of HALTED
        cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0011000, 16'd0,  "reset_from_halt");
        // Drain with a 2-cycle memory stall: halted delayed by 3 cycles
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd0,  "dw_halt");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd1,  "dw_stall_1");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd2,  "dw_stall_2");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 7'b0000000, 16'd3,  "dw_release");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd4,  "dw_drain_1");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd5,  "dw_drain_2");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd6,  "dw_drain_3");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0000110, 16'd7,  "dw_halted");
        cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0011000, 16'd0,  "reset_2");
        // Timeout: 4 wait cycles with mem_ready stuck low
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd0,  "to_stall");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd1,  "to_wait_1");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd2,  "to_wait_2");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd3,  "to_wait_3");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000100, 16'd4,  "to_wait_4");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 7'b0000111, 16'd5,  "to_err_halted");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 7'b0000111, 16'd5,  "to_err_sticky");
        // Asynchronous reset mid-DRAIN clears mem_err and stall_cnt at once
        cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0011000, 16'd0,  "reset_clears_err");
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd0,  "ar_halt");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0001000, 16'd1,  "ar_drain");
        cyc(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b0011000, 16'd0,  "ar_async_reset");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b1100000, 16'd0,  "ar_run");
        // Load-use beats halt: stays in RUN
        cyc(1, 5'd4, 5'd0, 1, 0, 1, 1, 5'd4, 0, 0, 0, 7'b0001000, 16'd0,  "lu_beats_halt");
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 7'b1100000, 16'd1,  "lu_then_run");

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_queue: got pending=%0d, expected pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
